// File: rtl/window_loader.sv
// window_loader: APB initiator that streams FFT_SIZE window coefficients from an
// AXI-Stream sink into a window_func instance. It first forces the responder to
// IDLE, then loads every coefficient word and finally arms the responder with
// CHANGE STATE, confirming WAIT through the status register.
//
// Optional build macro WINDOW_LOADER_READBACK_EN: each coefficient write is
// followed by a VERIFY read of the same word, and a mismatch aborts the run
// with err_code[3].
module window_loader #(
  parameter int FFT_SIZE = 8192,
  parameter int APB_AW   = $clog2(FFT_SIZE-1)+3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [3:0]        err_code,
  input  logic              coef_tvalid,
  output logic              coef_tready,
  input  logic              coef_tlast,
  input  logic [31:0]       coef_tdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [APB_AW-1:0] paddr,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata
);

  localparam int KW = $clog2(FFT_SIZE)+1;
  localparam logic [APB_AW-1:0] CTRL_ADDR = APB_AW'(FFT_SIZE*4);
  localparam logic [APB_AW-1:0] STAT_ADDR = APB_AW'((FFT_SIZE+1)*4);
  localparam logic [KW-1:0]     K_LAST    = KW'(FFT_SIZE-1);
  localparam logic [KW-1:0]     K_END     = KW'(FFT_SIZE);
  localparam logic [KW-1:0]     K_ONE     = KW'(1);

  localparam logic [31:0] CTRL_SRST_SET = 32'h0000_0001;
  localparam logic [31:0] CTRL_CLEAR    = 32'h0000_0000;
  localparam logic [31:0] CTRL_CHANGE   = 32'h0000_0100;

  localparam logic [1:0] RS_IDLE = 2'd0;
  localparam logic [1:0] RS_WAIT = 2'd1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR1,
    ST_CLR0,
    ST_STAT0,
    ST_FETCH,
    ST_LOAD,
`ifdef WINDOW_LOADER_READBACK_EN
    ST_VERIFY,
`endif
    ST_GO,
    ST_STAT1,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t            r_state;
  logic              r_phase;   // 0 = APB setup cycle, 1 = APB access cycle
  logic [KW-1:0]     r_k;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [3:0]        r_err_code;
  logic              r_tready;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [APB_AW-1:0] r_paddr;
  logic [31:0]       r_pwdata;

  logic [KW-1:0]     w_k_next;
  logic [APB_AW-1:0] w_coef_addr;
  logic              w_hs;
  logic              w_last_bad;
  logic              w_unused_prdata;

  assign w_k_next    = r_k + K_ONE;
  assign w_coef_addr = APB_AW'({r_k, 2'b00});
  assign w_hs        = coef_tvalid && r_tready;
  // tlast must sit exactly on the final coefficient; anything else is a framing error.
  assign w_last_bad  = (coef_tlast && (r_k < K_LAST)) || (!coef_tlast && (r_k == K_LAST));
  // Only the status FSM field of prdata matters in the default build.
  assign w_unused_prdata = ^{prdata[31:10], prdata[7:0]};

  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign err_code    = r_err_code;
  assign coef_tready = r_tready;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;

  // Sequencer FSM: every output is registered and set up one cycle ahead of use.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_phase    <= 1'b0;
      r_k        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 4'b0000;
      r_tready   <= 1'b0;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= 32'h0000_0000;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_CLR1;
            r_phase    <= 1'b0;
            r_k        <= '0;
            r_busy     <= 1'b1;
            r_err_code <= 4'b0000;
            r_psel     <= 1'b1;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b1;
            r_paddr    <= CTRL_ADDR;
            r_pwdata   <= CTRL_SRST_SET;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CLR1: begin
          if (!r_phase) begin
            r_phase   <= 1'b1;
            r_penable <= 1'b1;
          end else begin
            // Toggling bit0 back guarantees a soft reset edge in the responder.
            r_state   <= ST_CLR0;
            r_phase   <= 1'b0;
            r_penable <= 1'b0;
            r_pwdata  <= CTRL_CLEAR;
          end
        end
        ST_CLR0: begin
          if (!r_phase) begin
            r_phase   <= 1'b1;
            r_penable <= 1'b1;
          end else begin
            r_state   <= ST_STAT0;
            r_phase   <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= STAT_ADDR;
            r_pwdata  <= CTRL_CLEAR;
          end
        end
        ST_STAT0: begin
          if (!r_phase) begin
            r_phase   <= 1'b1;
            r_penable <= 1'b1;
          end else if (prdata[9:8] != RS_IDLE) begin
            r_state       <= ST_ERR;
            r_err         <= 1'b1;
            r_busy        <= 1'b0;
            r_err_code[0] <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
          end else begin
            r_state   <= ST_FETCH;
            r_phase   <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_tready  <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (w_hs && w_last_bad) begin
            r_state       <= ST_ERR;
            r_err         <= 1'b1;
            r_busy        <= 1'b0;
            r_err_code[1] <= 1'b1;
            r_tready      <= 1'b0;
          end else if (w_hs) begin
            r_state   <= ST_LOAD;
            r_phase   <= 1'b0;
            r_tready  <= 1'b0;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b1;
            r_paddr   <= w_coef_addr;
            r_pwdata  <= coef_tdata;
          end else begin
            r_state <= ST_FETCH;
          end
        end
        ST_LOAD: begin
          if (!r_phase) begin
            r_phase   <= 1'b1;
            r_penable <= 1'b1;
          end else begin
            r_k     <= w_k_next;
            r_phase <= 1'b0;
`ifdef WINDOW_LOADER_READBACK_EN
            // Re-read the word just written; paddr and pwdata are held for the compare.
            r_state   <= ST_VERIFY;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
`else
            if (w_k_next == K_END) begin
              r_state   <= ST_GO;
              r_penable <= 1'b0;
              r_pwrite  <= 1'b1;
              r_paddr   <= CTRL_ADDR;
              r_pwdata  <= CTRL_CHANGE;
            end else begin
              r_state   <= ST_FETCH;
              r_psel    <= 1'b0;
              r_penable <= 1'b0;
              r_pwrite  <= 1'b0;
              r_tready  <= 1'b1;
            end
`endif
          end
        end
`ifdef WINDOW_LOADER_READBACK_EN
        ST_VERIFY: begin
          if (!r_phase) begin
            r_phase   <= 1'b1;
            r_penable <= 1'b1;
          end else if (prdata != r_pwdata) begin
            r_state       <= ST_ERR;
            r_phase       <= 1'b0;
            r_err         <= 1'b1;
            r_busy        <= 1'b0;
            r_err_code[3] <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
          end else if (r_k == K_END) begin
            r_state   <= ST_GO;
            r_phase   <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b1;
            r_paddr   <= CTRL_ADDR;
            r_pwdata  <= CTRL_CHANGE;
          end else begin
            r_state   <= ST_FETCH;
            r_phase   <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_tready  <= 1'b1;
          end
        end
`endif
        ST_GO: begin
          if (!r_phase) begin
            r_phase   <= 1'b1;
            r_penable <= 1'b1;
          end else begin
            r_state   <= ST_STAT1;
            r_phase   <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= STAT_ADDR;
            r_pwdata  <= CTRL_CLEAR;
          end
        end
        ST_STAT1: begin
          if (!r_phase) begin
            r_phase   <= 1'b1;
            r_penable <= 1'b1;
          end else if (prdata[9:8] == RS_WAIT) begin
            r_state   <= ST_DONE;
            r_phase   <= 1'b0;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
          end else begin
            r_state       <= ST_ERR;
            r_phase       <= 1'b0;
            r_err         <= 1'b1;
            r_busy        <= 1'b0;
            r_err_code[2] <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
          end
        end
        ST_DONE: begin
          // start is deliberately not looked at here.
          r_state <= ST_IDLE;
        end
        ST_ERR: begin
          r_state <= ST_IDLE;
          r_phase <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_phase   <= 1'b0;
          r_busy    <= 1'b0;
          r_tready  <= 1'b0;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window_loader.sv
// Directed testbench for window_loader with FFT_SIZE=8 and a behavioural
// window_func APB responder (edge-triggered CTRL, status FSM in prdata[9:8]).
module tb_window_loader;

  localparam int N  = 8;
  localparam int AW = 6;
`ifdef WINDOW_LOADER_READBACK_EN
  localparam int EXP_DONE = 5*N+11;
`else
  localparam int EXP_DONE = 3*N+11;
`endif

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy, done, err;
  logic [3:0]    err_code;
  logic          coef_tvalid, coef_tready, coef_tlast;
  logic [31:0]   coef_tdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata, prdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  window_loader #(.FFT_SIZE(N), .APB_AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .coef_tvalid(coef_tvalid), .coef_tready(coef_tready),
    .coef_tlast(coef_tlast), .coef_tdata(coef_tdata), .psel(psel),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- window_func responder model ----------------
  logic [31:0] rs_mem [0:N-1];
  logic [31:0] rs_ctrl = 32'h0;
  logic [1:0]  rs_fsm  = 2'd2;
  bit          stuck   = 1'b0;
  bit          corrupt = 1'b0;

  // Responder register updates on completed write transfers.
  always @(posedge clk) begin
    if (psel && penable && pwrite) begin
      if (paddr == 6'd32) begin
        if (pwdata[0] != rs_ctrl[0]) rs_fsm <= 2'd0;
        else if (pwdata[8] != rs_ctrl[8] && rs_fsm == 2'd0) rs_fsm <= 2'd1;
        rs_ctrl <= pwdata;
      end else if (paddr < 6'd32) begin
        rs_mem[paddr[4:2]] <= pwdata;
      end
    end
  end

  // Zero-wait read data.
  always_comb begin
    prdata = rs_ctrl;
    if (paddr == 6'd36) prdata = stuck ? 32'h0000_0200 : {22'h0, rs_fsm, 8'h00};
    else if (paddr < 6'd32) prdata = rs_mem[paddr[4:2]] ^ ((corrupt && paddr == 6'd12) ? 32'h1 : 32'h0);
  end

  // ---------------- coefficient stream driver ----------------
  bit stream_en = 1'b0;
  bit toggle    = 1'b0;
  int tlast_pos = N-1;
  int beat = 0;
  bit pend = 1'b0;
  bit tph  = 1'b0;

  initial begin
    coef_tvalid = 1'b0; coef_tlast = 1'b0; coef_tdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!stream_en) begin
        beat = 0; pend = 1'b0; tph = 1'b0; coef_tvalid = 1'b0; coef_tlast = 1'b0;
      end else begin
        if (pend) beat++;
        tph = !tph;
        coef_tvalid = toggle ? tph : 1'b1;
        coef_tdata  = 32'h0001_0000 + 32'(beat);
        coef_tlast  = (beat == tlast_pos);
        pend = coef_tvalid && coef_tready;
      end
    end
  end

  // ---------------- APB monitor / logger ----------------
  int          wr_a[$];
  logic [31:0] wr_d[$];
  int          unstable = 0;
  int          tready_cnt = 0;
  bit          log_clr = 1'b0;
  logic [AW-1:0] su_a;
  logic          su_w;
  logic [31:0]   su_d;

  initial begin
    forever begin
      @(negedge clk);
      if (log_clr) begin
        wr_a.delete(); wr_d.delete(); unstable = 0; tready_cnt = 0;
      end else begin
        if (psel && !penable) begin su_a = paddr; su_w = pwrite; su_d = pwdata; end
        if (psel && penable) begin
          if (paddr !== su_a || pwrite !== su_w || pwdata !== su_d) unstable++;
          if (pwrite) begin wr_a.push_back(int'(paddr)); wr_d.push_back(pwdata); end
        end
        if (penable && !psel) unstable++;
        if (coef_tready) tready_cnt++;
      end
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  int s_cyc;
  int e_cyc;
  bit ended;

  task automatic clear_logs();
    log_clr = 1'b1;
    @(negedge clk); @(negedge clk);
    #1 log_clr = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    ended = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done || err) begin ended = 1'b1; e_cyc = cyc; break; end
      @(negedge clk);
    end
    checks++;
    if (!ended) begin errors++; $display("FAIL %s timeout: no done/err within 400 cycles", name); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({psel, penable, pwrite} !== 3'b000) begin errors++; $display("FAIL reset_apb_ctl got %b want 000", {psel, penable, pwrite}); end
    checks++; if (paddr !== 6'd0) begin errors++; $display("FAIL reset_paddr got %0d want 0", paddr); end
    checks++; if (pwdata !== 32'h0) begin errors++; $display("FAIL reset_pwdata got %h want 0", pwdata); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_status got %b want 000", {busy, done, err}); end
    checks++; if (err_code !== 4'b0000) begin errors++; $display("FAIL reset_err_code got %b want 0000", err_code); end
    checks++; if (coef_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", coef_tready); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || psel !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy=%b psel=%b want 0 0", busy, psel); end
  endtask

  task automatic check_full_run(input string name);
    checks++; if (wr_a.size() != N+3) begin errors++; $display("FAIL %s_write_count got %0d want %0d", name, wr_a.size(), N+3); end
    for (int i = 0; i < wr_a.size() && i < N+3; i++) begin
      int exp_a;
      logic [31:0] exp_d;
      if (i == 0) begin exp_a = 32; exp_d = 32'h1; end
      else if (i == 1) begin exp_a = 32; exp_d = 32'h0; end
      else if (i == N+2) begin exp_a = 32; exp_d = 32'h100; end
      else begin exp_a = 4*(i-2); exp_d = 32'h0001_0000 + 32'(i-2); end
      checks++;
      if (wr_a[i] != exp_a || wr_d[i] !== exp_d) begin
        errors++; $display("FAIL %s_write[%0d] got addr %0d data %h want addr %0d data %h", name, i, wr_a[i], wr_d[i], exp_a, exp_d);
      end
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL %s_apb_stable got %0d violations want 0", name, unstable); end
  endtask

  task automatic test_nominal();
    clear_logs();
    toggle = 1'b0; tlast_pos = N-1; stream_en = 1'b1;
    do_start();
    checks++; if (busy !== 1'b1 || psel !== 1'b1 || penable !== 1'b0) begin errors++; $display("FAIL nominal_first_setup busy=%b psel=%b penable=%b want 1 1 0", busy, psel, penable); end
    wait_end("nominal");
    checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL nominal_done done=%b err=%b want 1 0", done, err); end
    checks++; if (e_cyc - s_cyc != EXP_DONE) begin errors++; $display("FAIL nominal_latency got %0d want %0d", e_cyc - s_cyc, EXP_DONE); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nominal_busy_drop got %b want 0", busy); end
    checks++; if (err_code !== 4'b0000) begin errors++; $display("FAIL nominal_err_code got %b want 0000", err_code); end
    // start coinciding with DONE must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0 || psel !== 1'b0) begin errors++; $display("FAIL start_in_done busy=%b psel=%b want 0 0", busy, psel); end
    check_full_run("nominal");
    stream_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    clear_logs();
    stream_en = 1'b1;
    do_start();
    wait_end("b2b");
    checks++; if (done !== 1'b1 || e_cyc - s_cyc != EXP_DONE) begin errors++; $display("FAIL b2b_done done=%b latency=%0d want 1 %0d", done, e_cyc - s_cyc, EXP_DONE); end
    check_full_run("b2b");
    stream_en = 1'b0;
  endtask

  task automatic test_stuck_busy();
    clear_logs();
    stuck = 1'b1; stream_en = 1'b1;
    do_start();
    wait_end("stuck");
    checks++; if (err !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL stuck_err err=%b done=%b want 1 0", err, done); end
    checks++; if (e_cyc - s_cyc != 7) begin errors++; $display("FAIL stuck_err_cycle got %0d want 7", e_cyc - s_cyc); end
    checks++; if (err_code !== 4'b0001) begin errors++; $display("FAIL stuck_err_code got %b want 0001", err_code); end
    checks++; if (wr_a.size() != 2) begin errors++; $display("FAIL stuck_writes got %0d want 2", wr_a.size()); end
    checks++; if (tready_cnt != 0) begin errors++; $display("FAIL stuck_tready got %0d cycles want 0", tready_cnt); end
    stuck = 1'b0; stream_en = 1'b0;
    @(negedge clk);
    checks++; if (err_code !== 4'b0001) begin errors++; $display("FAIL stuck_sticky got %b want 0001", err_code); end
  endtask

  task automatic test_early_tlast();
    clear_logs();
    toggle = 1'b0; tlast_pos = 5; stream_en = 1'b1;
    do_start();
    wait_end("early_tlast");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL early_tlast_err got %b want 1", err); end
    checks++; if (err_code !== 4'b0010) begin errors++; $display("FAIL early_tlast_err_code got %b want 0010", err_code); end
    checks++; if (wr_a.size() != 7) begin errors++; $display("FAIL early_tlast_writes got %0d want 7", wr_a.size()); end
    for (int i = 2; i < wr_a.size(); i++) begin
      checks++;
      if (wr_a[i] != 4*(i-2)) begin errors++; $display("FAIL early_tlast_addr[%0d] got %0d want %0d", i, wr_a[i], 4*(i-2)); end
    end
    stream_en = 1'b0; tlast_pos = N-1;
  endtask

  task automatic test_backpressure();
    clear_logs();
    toggle = 1'b1; tlast_pos = N-1; stream_en = 1'b1;
    do_start();
    wait_end("backpressure");
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL backpressure_done got %b want 1", done); end
    checks++; if (err_code !== 4'b0000) begin errors++; $display("FAIL backpressure_err_code got %b want 0000", err_code); end
    check_full_run("backpressure");
    stream_en = 1'b0; toggle = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    bit hit;
    clear_logs();
    stream_en = 1'b1;
    do_start();
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (psel && penable && pwrite && paddr == 6'd12) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!hit) begin errors++; $display("FAIL rst_mid_reach got no access to addr 12 want one"); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (psel !== 1'b0 || penable !== 1'b0) begin errors++; $display("FAIL rst_mid_psel psel=%b penable=%b want 0 0", psel, penable); end
    checks++; if (busy !== 1'b0 || coef_tready !== 1'b0 || err_code !== 4'b0000) begin errors++; $display("FAIL rst_mid_outputs busy=%b tready=%b err_code=%b want 0 0 0000", busy, coef_tready, err_code); end
    rst = 1'b0; stream_en = 1'b0;
    @(negedge clk);
    clear_logs();
    stream_en = 1'b1;
    do_start();
    wait_end("rst_mid_rerun");
    checks++; if (done !== 1'b1 || err_code !== 4'b0000) begin errors++; $display("FAIL rst_mid_rerun done=%b err_code=%b want 1 0000", done, err_code); end
    check_full_run("rst_mid_rerun");
    stream_en = 1'b0;
  endtask

`ifdef WINDOW_LOADER_READBACK_EN
  task automatic test_readback();
    clear_logs();
    corrupt = 1'b1; stream_en = 1'b1;
    do_start();
    wait_end("readback");
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL readback_err got %b want 1", err); end
    checks++; if (err_code !== 4'b1000) begin errors++; $display("FAIL readback_err_code got %b want 1000", err_code); end
    checks++; if (e_cyc - s_cyc != 27) begin errors++; $display("FAIL readback_err_cycle got %0d want 27", e_cyc - s_cyc); end
    checks++; if (wr_a.size() != 6) begin errors++; $display("FAIL readback_writes got %0d want 6", wr_a.size()); end
    corrupt = 1'b0; stream_en = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_nominal();
    test_back_to_back();
    test_stuck_busy();
    test_early_tlast();
    test_backpressure();
    test_reset_mid_load();
`ifdef WINDOW_LOADER_READBACK_EN
    test_readback();
`endif
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
